ysyx_22051013_ifu_fq: RTL and testbench
=======================================

YSYX_22051013_IFU_FQ -- requirements
Module: ysyx_22051013_ifu_fq

Interface
REQ-001 Parameter PC_W, default 64, PC and fetch-address width.
REQ-002 Parameter DATA_W, default 64, memory response width; SHALL be 32 or 64.
REQ-003 Parameter FQ_DEPTH, default 4, instruction-queue entries; SHALL be a power of two, >=2.
REQ-004 Parameter START_PC, default 64'h8000_0000, reset fetch PC.
REQ-005 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst  input  1  synchronous reset, active when 0.
REQ-008 pc_stall  input  1  suppress new fetch requests.
REQ-009 ex_pc_jump / ex_pc_i  input  1 / PC_W  execute-stage redirect and target.
REQ-010 id_pc_jump / id_pc_i  input  1 / PC_W  decode-stage redirect and target.
REQ-011 bpu_pc_i  input  PC_W  predicted next PC for current pc_o.
REQ-012 imem_req_valid / imem_req_ready / imem_req_addr  output / input / output  1 / 1 / PC_W  fetch request handshake.
REQ-013 imem_resp_valid / imem_resp_data  input  1 / DATA_W  fetch response, no back-pressure.
REQ-014 inst_valid_o / inst_ready_i  output / input  1 / 1  decode-side handshake.
REQ-015 inst_o / inst_pc_o  output  32 / PC_W  queue-head instruction and its PC.
REQ-016 pc_o  output  PC_W  current fetch PC; fq_count_o  output  clog2(FQ_DEPTH)+1  queue occupancy.

Function
REQ-017 FSM states: REQ (no request outstanding), WAIT (one request accepted, response pending), DROP (stale request outstanding, its response is discarded); at most one outstanding request.
REQ-018 imem_req_valid SHALL equal (state==REQ && !pc_stall && fq_count_o<FQ_DEPTH && rst==1); imem_req_addr = pc_o.
REQ-019 Request fire (valid&&ready) without redirect: latch req_pc<=pc_o, pc_o<=bpu_pc_i, REQ->WAIT.
REQ-020 In WAIT, imem_resp_valid enqueues {inst, req_pc}; inst = DATA_W==64 ? (req_pc[2] ? data[63:32] : data[31:0]) : data[31:0]; WAIT->REQ same edge.
REQ-021 In DROP, imem_resp_valid is discarded, DROP->REQ; responses in REQ are ignored.
REQ-022 Redirect priority: ex_pc_jump > id_pc_jump > pc_stall > sequential; redirect sets pc_o<=ex_pc_i or id_pc_i.
REQ-023 Redirect flushes the queue (fq_count_o<=0) on the same edge; a simultaneous dequeue or enqueue is cancelled.
REQ-024 Redirect state update: REQ with fire -> DROP; REQ without fire -> REQ; WAIT without resp -> DROP; WAIT with resp -> REQ (resp discarded); DROP without resp -> DROP; DROP with resp -> REQ.
REQ-025 pc_stall SHALL hold pc_o and block new requests only; it SHALL NOT block responses, dequeues, or redirects.
REQ-026 Queue: FQ_DEPTH-entry circular buffer, pointers wrap modulo FQ_DEPTH; inst_valid_o = (fq_count_o!=0); inst_o/inst_pc_o driven from head entry, no added latency (enqueued entry visible next cycle).
REQ-027 Dequeue on inst_valid_o && inst_ready_i; simultaneous enqueue and dequeue keeps fq_count_o unchanged, valid at any occupancy including full.
REQ-028 Overflow SHALL be impossible: request gating guarantees a free slot for each response (full queue stalls requests, not responses).
REQ-029 imem_req_addr may change while valid&&!ready only on a redirect; otherwise held stable.

Reset
REQ-030 While rst==0: pc_o=START_PC, state=REQ, fq_count_o=0, pointers=0, inst_valid_o=0, imem_req_valid=0.
REQ-031 Reset mid-operation SHALL abandon any outstanding request; a response arriving in the first cycle after reset release is ignored (state REQ).
REQ-032 Queue storage contents need not be reset; inst_o/inst_pc_o are don't-care while inst_valid_o=0.

Verification
REQ-033 Reset release, ready=1, resp one cycle after fire with data 64'h00000013_00100093, bpu_pc_i=pc+4 -> addr 8000_0000 then 8000_0004; queue heads 00100093@8000_0000, 00000013@8000_0004.
REQ-034 inst_ready_i=0, FQ_DEPTH=4, continuous fetch -> fq_count_o reaches 4, imem_req_valid drops to 0; one dequeue -> one new request issues.
REQ-035 Redirect ex_pc_jump=1, ex_pc_i=8000_0100 while WAIT and queue holds 3 -> next cycle fq_count_o=0, state DROP, pending resp discarded, next addr 8000_0100.
REQ-036 ex_pc_jump (8000_0200) and id_pc_jump (8000_0300) same cycle -> pc_o=8000_0200.
REQ-037 pc_stall=1 for 5 cycles in REQ -> no fires, pc_o constant; resp in WAIT still enqueued; id redirect during stall updates pc_o.
REQ-038 rst=0 asserted in WAIT with queue count 2 -> next cycle pc_o=START_PC, fq_count_o=0; late response after release ignored.

Source files
------------

// File: rtl/ysyx_22051013_ifu_fq.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a small circular
// instruction queue; redirects flush the queue and orphan any in-flight request.
module ysyx_22051013_ifu_fq #(
  parameter int              PC_W     = 64,
  parameter int              DATA_W   = 64,
  parameter int              FQ_DEPTH = 4,
  parameter logic [PC_W-1:0] START_PC = PC_W'(64'h8000_0000)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pc_stall,
  input  logic                       ex_pc_jump,
  input  logic [PC_W-1:0]            ex_pc_i,
  input  logic                       id_pc_jump,
  input  logic [PC_W-1:0]            id_pc_i,
  input  logic [PC_W-1:0]            bpu_pc_i,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [PC_W-1:0]            imem_req_addr,
  input  logic                       imem_resp_valid,
  input  logic [DATA_W-1:0]          imem_resp_data,
  output logic                       inst_valid_o,
  input  logic                       inst_ready_i,
  output logic [31:0]                inst_o,
  output logic [PC_W-1:0]            inst_pc_o,
  output logic [PC_W-1:0]            pc_o,
  output logic [$clog2(FQ_DEPTH):0]  fq_count_o
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FQ_DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } fq_ent_t;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fq_ent_t          mem_q [FQ_DEPTH];

  logic        redirect, fire, enq, deq;
  logic [31:0] resp_inst;

  // A 64-bit response carries an aligned pair; the request PC picks the half.
  generate
    if (DATA_W == 64) begin : g_sel64
      assign resp_inst = req_pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
    end else begin : g_sel32
      assign resp_inst = imem_resp_data[31:0];
    end
  endgenerate

  assign imem_req_valid = rst && (state_q == S_REQ) && !pc_stall && (cnt_q < FULL);
  assign imem_req_addr  = pc_q;
  assign pc_o           = pc_q;
  assign fq_count_o     = cnt_q;
  assign inst_valid_o   = (cnt_q != '0);
  assign inst_o         = mem_q[head_q].inst;
  assign inst_pc_o      = mem_q[head_q].pc;

  assign redirect = ex_pc_jump || id_pc_jump;
  assign fire     = imem_req_valid && imem_req_ready;
  assign enq      = rst && (state_q == S_WAIT) && imem_resp_valid && !redirect;
  assign deq      = inst_valid_o && inst_ready_i && !redirect;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;

    // Any response closes the outstanding request; a redirect only decides
    // whether a still-pending one must be discarded.
    case (state_q)
      S_REQ:   if (fire) state_d = redirect ? S_DROP : S_WAIT;
      S_WAIT:  if (imem_resp_valid) state_d = S_REQ;
               else if (redirect) state_d = S_DROP;
      S_DROP:  if (imem_resp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    if (fire) req_pc_d = pc_q;

    if (ex_pc_jump)      pc_d = ex_pc_i;
    else if (id_pc_jump) pc_d = id_pc_i;
    else if (fire)       pc_d = bpu_pc_i;

    if (redirect) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (deq) head_d = head_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_REQ;
      pc_q     <= START_PC;
      req_pc_q <= START_PC;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is left unreset; the count alone qualifies the head entry.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= '{inst: resp_inst, pc: req_pc_q};
  end

endmodule

// File: tb/tb_ysyx_22051013_ifu_fq.sv
// Bench for ysyx_22051013_ifu_fq: directed scenarios pinned with literals, then
// randomized traffic checked every cycle against a queue-based behavioural model.
module tb_ysyx_22051013_ifu_fq;

  localparam logic [63:0] START = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, pc_stall, ex_pc_jump, id_pc_jump;
  logic [63:0] ex_pc_i, id_pc_i, bpu_pc_i;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o, pc_o;
  logic [2:0]  fq_count_o;

  always #5 clk = ~clk;

  ysyx_22051013_ifu_fq dut (
    .clk(clk), .rst(rst), .pc_stall(pc_stall),
    .ex_pc_jump(ex_pc_jump), .ex_pc_i(ex_pc_i),
    .id_pc_jump(id_pc_jump), .id_pc_i(id_pc_i), .bpu_pc_i(bpu_pc_i),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .pc_o(pc_o), .fq_count_o(fq_count_o)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: fetch PC, what the single outstanding request is worth
  // (0 none, 1 live, 2 stale) and a plain queue of delivered instructions.
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;
  logic [63:0] m_pc, m_reqpc;
  int          m_out;
  ent_t        m_q[$];

  // Memory: answers each accepted request after mem_lat idle cycles.
  bit          mem_pend;
  int          mem_cnt;
  int          mem_lat;
  logic [63:0] mem_addr;
  bit          spur_en;
  int          bpu_step;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0010_0093;
    if (a == 64'h8000_0004) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]} ^ 32'h5a00_00a5;
  endfunction

  function automatic logic [63:0] mkdata(input logic [63:0] a);
    return {inst_of(a | 64'd4), inst_of(a & ~64'd4)};
  endfunction

  task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive memory response, compare outputs, advance model and memory.
  task automatic cyc();
    bit          exp_v, fire_m, redir, can_deq, push, dut_fire;
    logic [63:0] fire_addr;
    ent_t        e;
    imem_resp_valid = 1'b0;
    imem_resp_data  = {$urandom, $urandom};
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mkdata(mem_addr);
        mem_pend        = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else if (spur_en && $urandom_range(0, 19) == 0) begin
      imem_resp_valid = 1'b1;
    end
    bpu_pc_i = m_pc + 64'(bpu_step);
    #1;
    exp_v = rst && (m_out == 0) && !pc_stall && (m_q.size() < 4);
    ck("req_valid", 64'(imem_req_valid), 64'(exp_v));
    ck("req_addr", imem_req_addr, m_pc);
    ck("pc_o", pc_o, m_pc);
    ck("fq_count", 64'(fq_count_o), 64'(m_q.size()));
    ck("inst_valid", 64'(inst_valid_o), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      ck("inst_o", 64'(inst_o), 64'(m_q[0].inst));
      ck("inst_pc", inst_pc_o, m_q[0].pc);
    end
    dut_fire  = imem_req_valid && imem_req_ready;
    fire_addr = imem_req_addr;

    if (!rst) begin
      m_pc  = START;
      m_out = 0;
      m_q.delete();
    end else begin
      redir   = ex_pc_jump || id_pc_jump;
      fire_m  = exp_v && imem_req_ready;
      can_deq = (m_q.size() != 0) && inst_ready_i && !redir;
      push    = 1'b0;
      if (m_out != 0 && imem_resp_valid) begin
        if (m_out == 1 && !redir) begin
          push   = 1'b1;
          e.inst = m_reqpc[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
          e.pc   = m_reqpc;
        end
        m_out = 0;
      end else if (m_out != 0 && redir) begin
        m_out = 2;
      end
      if (can_deq) void'(m_q.pop_front());
      if (push) m_q.push_back(e);
      if (redir) m_q.delete();
      if (fire_m) begin
        m_out   = redir ? 2 : 1;
        m_reqpc = m_pc;
      end
      if (ex_pc_jump)      m_pc = ex_pc_i;
      else if (id_pc_jump) m_pc = id_pc_i;
      else if (fire_m)     m_pc = bpu_pc_i;
    end

    @(posedge clk);
    if (dut_fire) begin
      mem_pend = 1'b1;
      mem_cnt  = mem_lat;
      mem_addr = fire_addr;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; pc_stall = 1'b0; ex_pc_jump = 1'b0; id_pc_jump = 1'b0;
    ex_pc_i = '0; id_pc_i = '0; bpu_pc_i = '0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    inst_ready_i = 1'b0;
    mem_pend = 1'b0; mem_cnt = 0; mem_lat = 0; mem_addr = '0;
    spur_en = 1'b0; bpu_step = 4;
    m_pc = START; m_reqpc = START; m_out = 0;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    repeat (3) cyc();
    ck("rst_pc", pc_o, 64'h8000_0000);
    ck("rst_count", 64'(fq_count_o), 64'd0);
    ck("rst_valid", 64'(inst_valid_o), 64'd0);
    ck("rst_req", 64'(imem_req_valid), 64'd0);

    // Two sequential fetches from one 64-bit line
    rst = 1'b1;
    cyc();
    cyc();
    ck("seq_count1", 64'(fq_count_o), 64'd1);
    ck("seq_inst0", 64'(inst_o), 64'h0010_0093);
    ck("seq_pc0", inst_pc_o, 64'h8000_0000);
    ck("seq_addr1", imem_req_addr, 64'h8000_0004);
    cyc();
    cyc();
    ck("seq_count2", 64'(fq_count_o), 64'd2);
    inst_ready_i = 1'b1;
    cyc();
    inst_ready_i = 1'b0;
    ck("seq_inst1", 64'(inst_o), 64'h0000_0013);
    ck("seq_pc1", inst_pc_o, 64'h8000_0004);

    // Fill to full, then one dequeue reopens requests
    repeat (12) cyc();
    ck("full_count", 64'(fq_count_o), 64'd4);
    ck("full_noreq", 64'(imem_req_valid), 64'd0);
    inst_ready_i = 1'b1;
    cyc();
    inst_ready_i = 1'b0;
    ck("deq_count", 64'(fq_count_o), 64'd3);
    ck("deq_req", 64'(imem_req_valid), 64'd1);

    // Execute redirect while a response is pending
    mem_lat = 2;
    cyc();
    ck("wait_count", 64'(fq_count_o), 64'd3);
    ex_pc_jump = 1'b1; ex_pc_i = 64'h8000_0100;
    cyc();
    ex_pc_jump = 1'b0;
    ck("ex_flush", 64'(fq_count_o), 64'd0);
    ck("ex_pc", pc_o, 64'h8000_0100);
    ck("ex_drop_noreq", 64'(imem_req_valid), 64'd0);
    mem_lat = 0;
    cyc();
    cyc();
    ck("ex_after_drop_req", 64'(imem_req_valid), 64'd1);
    ck("ex_after_drop_addr", imem_req_addr, 64'h8000_0100);
    ck("ex_after_drop_cnt", 64'(fq_count_o), 64'd0);

    // Simultaneous redirects: execute wins
    ex_pc_jump = 1'b1; ex_pc_i = 64'h8000_0200;
    id_pc_jump = 1'b1; id_pc_i = 64'h8000_0300;
    cyc();
    ex_pc_jump = 1'b0; id_pc_jump = 1'b0;
    ck("prio_pc", pc_o, 64'h8000_0200);

    // Stall holds the PC but not responses or redirects
    pc_stall = 1'b1;
    repeat (6) cyc();
    ck("stall_pc", pc_o, 64'h8000_0200);
    ck("stall_noreq", 64'(imem_req_valid), 64'd0);
    pc_stall = 1'b0; mem_lat = 1;
    cyc();
    pc_stall = 1'b1;
    cyc();
    cyc();
    ck("stall_enq_cnt", 64'(fq_count_o), 64'd1);
    ck("stall_enq_pc", inst_pc_o, 64'h8000_0200);
    ck("stall_fetch_pc", pc_o, 64'h8000_0204);
    id_pc_jump = 1'b1; id_pc_i = 64'h8000_0300;
    cyc();
    id_pc_jump = 1'b0;
    ck("stall_id_pc", pc_o, 64'h8000_0300);
    ck("stall_id_flush", 64'(fq_count_o), 64'd0);

    // Reset mid-operation, late response after release
    pc_stall = 1'b0; mem_lat = 0;
    repeat (4) cyc();
    mem_lat = 1;
    cyc();
    ck("pre_rst_count", 64'(fq_count_o), 64'd2);
    rst = 1'b0;
    cyc();
    ck("mid_rst_pc", pc_o, START);
    ck("mid_rst_count", 64'(fq_count_o), 64'd0);
    rst = 1'b1;
    cyc();
    ck("late_resp_ignored", 64'(fq_count_o), 64'd0);
    ck("late_resp_pc", pc_o, 64'h8000_0004);

    // Randomized traffic
    spur_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(0, 199) != 0);
      pc_stall       = ($urandom_range(0, 4) == 0);
      ex_pc_jump     = ($urandom_range(0, 24) == 0);
      id_pc_jump     = ($urandom_range(0, 19) == 0);
      ex_pc_i        = START + 64'($urandom_range(0, 1023) << 2);
      id_pc_i        = START + 64'($urandom_range(0, 1023) << 2);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      inst_ready_i   = ($urandom_range(0, 1) == 1);
      mem_lat        = $urandom_range(0, 3);
      bpu_step       = ($urandom_range(0, 3) == 0) ? 8 : 4;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
